rgb_sequencer: RTL and testbench
================================

# rgb_sequencer

Color sequencer feeding the RGB PWM controller's 8-bit red/green/blue inputs. It replaces the fixed switch-to-color wiring with four modes: manual (switch RGB565), palette step, palette fade and off. It also exports the current palette index so the seven-segment path can display it. It sits between the board inputs (switches/buttons) and the RGB controller in the top level.

## Interface
- TICK_DIV, 100000, CLK cycles per sequencer tick (1 kHz at 100 MHz); legal range ≥ 2
- DWELL_TICKS, 500, ticks a palette color is held before advancing; legal range ≥ 1
- FADE_STEP, 1, per-tick increment/decrement applied to each channel in fade mode; legal range 1..255
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  asynchronous, active-high reset
- mode_in  input  2  00 manual, 01 step, 10 fade, 11 off
- manual_in  input  16  RGB565 color for manual mode (R=[15:11], G=[10:5], B=[4:0])
- pause_in  input  1  level; freezes prescaler, dwell counter and fade progress
- r_out / g_out / b_out  output  8 each  channel duty values to the RGB controller
- update_out  output  1  one-cycle pulse in the cycle any of r/g/b_out changes value
- idx_out  output  3  current palette index

## Operation
- Palette, index 0..7: FF0000, FFFF00, 00FF00, 00FFFF, 0000FF, FF00FF, FFFFFF, FF8000.
- FSM states: OFF, MANUAL, HOLD, FADE. The reset state is OFF. mode_in is sampled every cycle; a mode change is entered on the next edge from any state.
- OFF: outputs are 0. idx is preserved. The prescaler and dwell counter are cleared.
- MANUAL: outputs are {R5,3'b0}, {G6,2'b0}, {B5,3'b0} from manual_in. The value is registered with 1-cycle latency and tracks manual_in continuously. idx is preserved.
- Step mode (01):
  - On entry, outputs load palette[idx] on the next edge and the FSM enters HOLD.
  - After DWELL_TICKS ticks in HOLD, idx advances (7 wraps to 0), outputs load the new color, and the FSM re-enters HOLD with the dwell count cleared.
- Fade mode (10):
  - On entry, target = palette[idx] and the FSM enters FADE from the current output values.
  - On each tick, each channel moves toward its target by FADE_STEP and saturates exactly at the target (no overshoot, no wrap).
  - When all three channels equal the target, the FSM goes to HOLD.
  - After DWELL_TICKS ticks, idx advances (wrap 7 to 0), the target is updated, and the FSM returns to FADE.
- Switching between step and fade preserves idx and the current outputs.
- Pause: while pause_in=1, the prescaler, dwell counter and fade do not advance and the outputs hold. MANUAL and OFF are unaffected by pause.
- update_out is registered and compares the new and old output values. Mode or idx changes that leave the color unchanged produce no pulse.

## Timing
- Reset values:
  - r/g/b_out = 0, update_out = 0, idx_out = 0, state OFF.
  - Prescaler = 0, dwell = 0.
  - RST asserted mid-fade or mid-dwell aborts immediately to these values.
- Prescaler:
  - Counts 0..TICK_DIV-1; the tick is a 1-cycle strobe in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
  - Cleared on every state entry, so the first tick after entry is TICK_DIV cycles later.
- HOLD duration: exactly DWELL_TICKS×TICK_DIV cycles from HOLD entry to the idx advance, pause excluded.
- Output latency:
  - 1 cycle from a mode_in or manual_in change to the outputs.
  - 1 cycle from the tick strobe to the fade step.
  - update_out is coincident with the new output value.
- Fade and dwell simultaneity: if the last fade step reaches the target on a tick, HOLD entry and dwell counting start on the following cycle. The arrival tick does not count toward dwell.

## Configuration
- RGBSEQ_GAMMA_EN defined:
  - Each channel passes through out = (x·(x+1))>>8 before the output registers (0→0, 128→64, 255→255).
  - Adds one register stage: all output latencies become +1 cycle and update_out is delayed to match.
  - Internal fade and target comparisons use the linear values.
- Undefined: outputs are the linear values with the latencies above.

## Test plan
Use TICK_DIV=4, DWELL_TICKS=3, FADE_STEP=64, no gamma.
- Reset then manual: RST pulse, then mode 00 with manual_in=16'hF81F → one cycle later outputs F8/00/F8, update_out=1 for that single cycle.
- Step: mode 01 from reset → outputs FF/00/00 with idx 0 next cycle. idx becomes 1 (FF/FF/00) 12 cycles later. After 8 advances idx wraps to 0.
- Fade: from OFF enter mode 10 → red climbs 0,64,128,192,255 on successive ticks (every 4 cycles). Green and blue stay 0. Then HOLD 12 cycles, then target FFFF00 with green ramping.
- Pause: assert pause_in for 40 cycles mid-fade → outputs and idx frozen, no update_out. On release, the ramp resumes from the held value.
- Mid-operation: mode 11 during HOLD → outputs 0 next cycle. Return to 01 → palette[same idx] is reloaded. Asserting RST during FADE clears all outputs asynchronously within the same cycle.
- Gamma (RGBSEQ_GAMMA_EN): manual_in = 16'h8410 (R=80) → r_out=40, 2-cycle latency.

Source files
------------

// File: rtl/rgb_sequencer_if.sv
// Board-side controls into the colour sequencer and the channel duties it drives.
// The master drives mode, manual and pause; the slave returns the colour, the update pulse and the palette index.
interface rgb_sequencer_if;
  logic [1:0]  mode;
  logic [15:0] manual;
  logic        pause;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        update;
  logic [2:0]  idx;

  modport master (output mode, manual, pause, input r, g, b, update, idx);
  modport slave  (input mode, manual, pause, output r, g, b, update, idx);
endinterface

// File: rtl/rgb_sequencer.sv
// Colour sequencer with manual, palette step, palette fade and off modes. Latency is 1 cycle, or 2 with RGBSEQ_GAMMA_EN.
// There is no backpressure: the outputs are recomputed every cycle, and pause only freezes the step and fade timing.
module rgb_sequencer #(
  parameter int TICK_DIV    = 100000,
  parameter int DWELL_TICKS = 500,
  parameter int FADE_STEP   = 1
) (
  input  logic           clk,
  input  logic           rst,
  rgb_sequencer_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
  localparam logic [8:0]    STEP       = 9'(FADE_STEP);

  typedef enum logic [1:0] {OFF, MANUAL, HOLD, FADE} state_t;

  state_t        state, state_n;
  logic [1:0]    mode_q;
  logic [2:0]    idx, idx_n;
  logic [23:0]   rgb, rgb_n, tgt, stepped;
  logic [PW-1:0] presc;
  logic [DW-1:0] dwell;
  logic          upd;
  logic          tick, last_dwell, mode_chg, restart;

  function automatic logic [23:0] palette(input logic [2:0] i);
    case (i)
      3'd0:    return 24'hFF0000;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FF00;
      3'd3:    return 24'h00FFFF;
      3'd4:    return 24'h0000FF;
      3'd5:    return 24'hFF00FF;
      3'd6:    return 24'hFFFFFF;
      default: return 24'hFF8000;
    endcase
  endfunction

  // Move one channel toward its target by STEP, landing exactly on the target.
  function automatic logic [7:0] approach(input logic [7:0] cur, input logic [7:0] t);
    logic [8:0] c9, t9;
    c9 = {1'b0, cur};
    t9 = {1'b0, t};
    if (c9 < t9)      return ((t9 - c9) <= STEP) ? t : 8'(c9 + STEP);
    else if (c9 > t9) return ((c9 - t9) <= STEP) ? t : 8'(c9 - STEP);
    else              return cur;
  endfunction

  assign tick       = !bus.pause && (presc == PRESC_LAST);
  assign last_dwell = (dwell == DWELL_LAST);
  assign mode_chg   = (bus.mode != mode_q);
  assign tgt        = palette(idx);
  assign stepped    = {approach(rgb[23:16], tgt[23:16]),
                       approach(rgb[15:8],  tgt[15:8]),
                       approach(rgb[7:0],   tgt[7:0])};

  always_comb begin
    state_n = state;
    idx_n   = idx;
    rgb_n   = rgb;
    restart = 1'b0;
    case (bus.mode)
      2'b11: begin
        state_n = OFF;
        rgb_n   = '0;
      end
      2'b00: begin
        state_n = MANUAL;
        rgb_n   = {bus.manual[15:11], 3'b000, bus.manual[10:5], 2'b00, bus.manual[4:0], 3'b000};
      end
      2'b01: begin
        if (mode_chg) begin
          // Coming from fade keeps whatever colour the fade had reached.
          state_n = HOLD;
          restart = 1'b1;
          if (mode_q != 2'b10) rgb_n = tgt;
        end else if (tick && last_dwell) begin
          idx_n   = idx + 3'd1;
          rgb_n   = palette(idx + 3'd1);
          state_n = HOLD;
          restart = 1'b1;
        end
      end
      default: begin
        if (mode_chg) begin
          state_n = FADE;
          restart = 1'b1;
        end else if (state == FADE) begin
          if (rgb == tgt) begin
            state_n = HOLD;
            restart = 1'b1;
          end else if (tick) begin
            rgb_n = stepped;
            // Dwell starts the cycle after the arrival tick, not on it.
            if (stepped == tgt) begin
              state_n = HOLD;
              restart = 1'b1;
            end
          end
        end else if (tick && last_dwell) begin
          idx_n   = idx + 3'd1;
          state_n = FADE;
          restart = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= OFF;
      mode_q <= 2'b11;
      idx    <= '0;
      rgb    <= '0;
      upd    <= 1'b0;
      presc  <= '0;
      dwell  <= '0;
    end else begin
      state  <= state_n;
      mode_q <= bus.mode;
      idx    <= idx_n;
      rgb    <= rgb_n;
      upd    <= (rgb_n != rgb);
      if (restart || state_n == OFF || state_n == MANUAL)
        presc <= '0;
      else if (!bus.pause)
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      if (restart || state_n != HOLD)
        dwell <= '0;
      else if (tick)
        dwell <= dwell + 1'b1;
    end
  end

`ifdef RGBSEQ_GAMMA_EN
  logic [23:0] rgb_g, gam_n;
  logic        upd_g;
  logic [2:0]  idx_g;

  function automatic logic [7:0] gamma(input logic [7:0] x);
    logic [15:0] p;
    p = {8'd0, x} * ({8'd0, x} + 16'd1);
    return p[15:8];
  endfunction

  assign gam_n = {gamma(rgb[23:16]), gamma(rgb[15:8]), gamma(rgb[7:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_g <= '0;
      upd_g <= 1'b0;
      idx_g <= '0;
    end else begin
      rgb_g <= gam_n;
      upd_g <= (gam_n != rgb_g);
      idx_g <= idx;
    end
  end

  assign bus.r      = rgb_g[23:16];
  assign bus.g      = rgb_g[15:8];
  assign bus.b      = rgb_g[7:0];
  assign bus.update = upd_g;
  assign bus.idx    = idx_g;
`else
  assign bus.r      = rgb[23:16];
  assign bus.g      = rgb[15:8];
  assign bus.b      = rgb[7:0];
  assign bus.update = upd;
  assign bus.idx    = idx;
`endif

endmodule

// File: tb/tb_rgb_sequencer.sv
// Randomized bench for rgb_sequencer: an elapsed-time colour model fills a scoreboard queue,
// and a monitor pops and compares one entry after each clock edge.
module tb_rgb_sequencer;
  localparam int TD = 4;
  localparam int DW = 3;
  localparam int FS = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rgb_sequencer_if bus ();
  rgb_sequencer #(.TICK_DIV(TD), .DWELL_TICKS(DW), .FADE_STEP(FS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [23:0] pal [8] = '{24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
                           24'h0000FF, 24'hFF00FF, 24'hFFFFFF, 24'hFF8000};

  int checks = 0;
  int failures = 0;
  logic [27:0] q [$];

  // Reference state: colour, index, the mode last seen, fade/hold phase, and cycles spent in the phase.
  int m_idx, prev_mode, fading, tcnt;
  int cur [3];

  task automatic model_reset();
    m_idx = 0; prev_mode = 3; fading = 0; tcnt = 0;
    for (int c = 0; c < 3; c++) cur[c] = 0;
  endtask

  function automatic int chan(input logic [23:0] col, input int c);
    logic [23:0] v;
    v = col >> (8 * (2 - c));
    return int'(v[7:0]);
  endfunction

  function automatic logic at_target();
    for (int c = 0; c < 3; c++) if (cur[c] != chan(pal[m_idx], c)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_cycle(input int md, input logic [15:0] man, input logic pz);
    int old [3];
    logic entry, upd;
    for (int c = 0; c < 3; c++) old[c] = cur[c];
    entry = (md != prev_mode);
    case (md)
      3: begin
        for (int c = 0; c < 3; c++) cur[c] = 0;
        fading = 0; tcnt = 0;
      end
      0: begin
        cur[0] = int'(man[15:11]) * 8;
        cur[1] = int'(man[10:5]) * 4;
        cur[2] = int'(man[4:0]) * 8;
        fading = 0; tcnt = 0;
      end
      1: begin
        if (entry) begin
          if (prev_mode != 2) for (int c = 0; c < 3; c++) cur[c] = chan(pal[m_idx], c);
          fading = 0; tcnt = 0;
        end else if (!pz) begin
          tcnt++;
          if (tcnt == DW * TD) begin
            m_idx = (m_idx + 1) % 8;
            for (int c = 0; c < 3; c++) cur[c] = chan(pal[m_idx], c);
            tcnt = 0;
          end
        end
      end
      default: begin
        if (entry) begin
          fading = 1; tcnt = 0;
        end else if (fading != 0) begin
          if (at_target()) begin
            fading = 0; tcnt = 0;
          end else if (!pz) begin
            tcnt++;
            if (tcnt % TD == 0) begin
              for (int c = 0; c < 3; c++) begin
                int t;
                t = chan(pal[m_idx], c);
                if (cur[c] < t) cur[c] = (cur[c] + FS > t) ? t : cur[c] + FS;
                else if (cur[c] > t) cur[c] = (cur[c] - FS < t) ? t : cur[c] - FS;
              end
              if (at_target()) begin fading = 0; tcnt = 0; end
            end
          end
        end else if (!pz) begin
          tcnt++;
          if (tcnt == DW * TD) begin
            m_idx = (m_idx + 1) % 8;
            fading = 1; tcnt = 0;
          end
        end
      end
    endcase
    prev_mode = md;
    upd = (old[0] != cur[0]) || (old[1] != cur[1]) || (old[2] != cur[2]);
    q.push_back({8'(cur[0]), 8'(cur[1]), 8'(cur[2]), upd, 3'(m_idx)});
  endtask

  task automatic drive(input int md, input logic [15:0] man, input logic pz, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.mode = 2'(md); bus.manual = man; bus.pause = pz;
      model_cycle(md, man, pz);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({bus.r, bus.g, bus.b, bus.update, bus.idx} !== 28'd0) begin
      failures++;
      $display("FAIL %s got r=%h g=%h b=%h upd=%b idx=%0d want all zero",
               name, bus.r, bus.g, bus.b, bus.update, bus.idx);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.mode = 2'b11; bus.pause = 1'b0;
    model_reset();
    q.push_back(28'd0);
    #1 check_zero("async_reset");
    repeat (2) begin @(negedge clk); q.push_back(28'd0); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    logic [27:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {bus.r, bus.g, bus.b, bus.update, bus.idx};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL sb t=%0t got r=%h g=%h b=%h upd=%b idx=%0d want r=%h g=%h b=%h upd=%b idx=%0d",
                   $time, got[27:20], got[19:12], got[11:4], got[3], got[2:0],
                   e[27:20], e[19:12], e[11:4], e[3], e[2:0]);
        end
      end
    end
  end

  initial begin : stim
    int md, n;
    logic [15:0] man;
    logic pz;
    bus.mode = 2'b11; bus.manual = '0; bus.pause = 1'b0;
    model_reset();
    #2 rst = 1'b1;
    #1 check_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    drive(0, 16'hF81F, 0, 3);
    repeat (20) drive(0, 16'($urandom), 0, 1);
    drive(3, 0, 0, 3);
    drive(1, 0, 0, 8 * 12 + 6);            // full palette wrap in step mode
    drive(3, 0, 0, 2);
    drive(2, 0, 0, 10);
    drive(2, 0, 1, 40);                    // pause mid-ramp
    drive(2, 0, 0, 60);
    drive(1, 0, 0, 14);
    drive(3, 0, 0, 2);
    drive(1, 0, 0, 5);
    drive(3, 0, 0, 2);
    drive(1, 0, 0, 15);
    drive(2, 0, 0, 9);
    do_reset();

    repeat (50) begin
      md  = $urandom_range(0, 3);
      n   = $urandom_range(1, 60);
      man = 16'($urandom);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 7) == 0) man = 16'($urandom);
        pz = ($urandom_range(0, 11) == 0);
        drive(md, man, pz, 1);
      end
    end
    drive(2, 0, 0, 7);
    do_reset();
    drive(3, 0, 0, 2);

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
